// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle data-memory access sequencer for the MIPS MEM stage.
// Takes one load/store at a time, drives a word-wide req/ack memory port,
// selects and extends byte/half load data, replicates store data and builds
// byte enables, and stalls the pipeline until the access completes, faults
// (illegal size or misalignment) or times out after TIMEOUT wait cycles.
// Optional build macro MEM_ACC_STATS_EN adds saturating acc_cnt/err_cnt outputs.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
`ifdef MEM_ACC_STATS_EN
    ,
    output logic [15:0] acc_cnt,
    output logic [15:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

    state_e      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  off_q, off_d;
    logic [15:0] cnt_q, cnt_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [1:0]  req_off;
    logic        req_illegal;
    logic [3:0]  req_be;
    logic [31:0] req_wdata_rep;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic        timeout_hit;

    // Decode the incoming request: legality, byte enables, replicated store data
    always_comb begin
        req_off       = req_addr[1:0];
        req_illegal   = 1'b0;
        req_be        = 4'b0000;
        req_wdata_rep = req_wdata;
        case (req_size)
            2'b00: begin
                req_be        = 4'b0001 << req_off;
                req_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                req_be        = 4'b0011 << req_off;
                req_wdata_rep = {2{req_wdata[15:0]}};
                req_illegal   = req_off[0];
            end
            2'b10: begin
                req_be      = 4'b1111;
                req_illegal = (req_off != 2'b00);
            end
            default: req_illegal = 1'b1;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it
    always_comb begin
        lane_b = mem_rdata[{off_q, 3'b000} +: 8];
        lane_h = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_data = {{24{lane_b[7] & signed_q}}, lane_b};
            2'b01:   load_data = {{16{lane_h[15] & signed_q}}, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    assign timeout_hit = ({1'b0, cnt_q} + 17'd1) == TIMEOUT_L;

    // Next-state logic for the IDLE -> WAIT -> RESP access sequence
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        size_d       = size_q;
        signed_d     = signed_q;
        off_d        = off_q;
        cnt_d        = cnt_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d   = req_size;
                    signed_d = req_signed;
                    off_d    = req_off;
                    cnt_d    = '0;
                    if (req_illegal) begin
                        state_d      = S_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = S_WAIT;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = req_be;
                        mem_wdata_d = req_wdata_rep;
                    end
                end
            end
            S_WAIT: begin
                // ack takes priority over a timeout landing in the same cycle
                if (mem_ack) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    cnt_d        = '0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? '0 : load_data;
                end else if (timeout_hit) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    cnt_d        = '0;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            off_q        <= '0;
            cnt_q        <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            off_q        <= off_d;
            cnt_q        <= cnt_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = rst_n & (state_q == S_IDLE);
    assign stall      = rst_n & (((state_q == S_IDLE) & req_valid) | (state_q == S_WAIT));
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef MEM_ACC_STATS_EN
    logic [15:0] acc_cnt_q, err_cnt_q;

    // Saturating response counters, split by error status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (state_q == S_RESP) begin
            if (resp_err_q) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 16'd1;
            end else begin
                if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + 16'd1;
            end
        end
    end

    assign acc_cnt = acc_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule
